branch_predictor: RTL and testbench

- Branch prediction and resolution unit for the pipelined RV32I core.
- Fetch side: predicts conditional branches from a direct-mapped table of tagged 2-bit saturating counters with stored targets.
- Execute side: takes br_less/br_equal from the branch comparator and drives its unsigned-select, computes the actual outcome from funct3, flags mispredicts, supplies the redirect PC and trains the table.
- Also keeps branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor and resolver: tagged 2-bit counter table with stored targets,
// funct3 outcome decode, mispredict/redirect generation and branch statistics.
module branch_predictor #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_pc_o,
    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pred_pc_i,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsigned_o,
    output logic        br_taken_o,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] br_count_o,
    output logic [31:0] miss_count_o
);
    localparam int unsigned ENTRIES = 1 << INDEX_W;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        br_count_q;
    logic [31:0]        miss_count_q;

    logic [INDEX_W-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   ex_tag;
    logic               ex_hit;
    logic               legal;
    logic               outcome;
    logic               res;

    assign f_idx  = pc_f_i[INDEX_W+1:2];
    assign f_tag  = pc_f_i[INDEX_W+TAG_W+1:INDEX_W+2];
    assign ex_idx = ex_pc_i[INDEX_W+1:2];
    assign ex_tag = ex_pc_i[INDEX_W+TAG_W+1:INDEX_W+2];

    // Fetch-side lookup reads pre-update table contents (no bypass)
    assign f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_o = f_hit && ctr_q[f_idx][1];
    assign pred_pc_o    = pred_taken_o ? target_q[f_idx] : pc_f_i + 32'd4;

    assign br_unsigned_o = ex_funct3_i[1];

    // Outcome decode; 010/011 are not branches
    always_comb begin
        legal   = 1'b1;
        outcome = 1'b0;
        case (ex_funct3_i)
            3'b000:         outcome = br_equal_i;
            3'b001:         outcome = ~br_equal_i;
            3'b100, 3'b110: outcome = br_less_i;
            3'b101, 3'b111: outcome = ~br_less_i;
            default:        legal   = 1'b0;
        endcase
    end

    assign res           = ex_valid_i && ex_is_br_i && legal;
    assign br_taken_o    = res && outcome;
    assign mispredict_o  = res && ((br_taken_o != ex_pred_taken_i) ||
                                   (br_taken_o && (ex_pred_pc_i != ex_target_i)));
    assign redirect_pc_o = br_taken_o ? ex_target_i : ex_pc_i + 32'd4;

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Table training on resolved branches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (res) begin
            if (ex_hit) begin
                if (br_taken_o) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= ex_target_i;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (br_taken_o) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target_i;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    // Wrapping statistics counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            if (res) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mispredict_o) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign br_count_o   = br_count_q;
    assign miss_count_o = miss_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: per-cycle comparison against a table model
// plus literal checks of the key scenarios.
module tb_branch_predictor;
    localparam int unsigned INDEX_W = 6;
    localparam int unsigned TAG_W   = 8;
    localparam int NENT = 1 << INDEX_W;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        ex_valid, ex_is_br;
    logic [31:0] ex_pc, ex_target, ex_pred_pc;
    logic [2:0]  ex_funct3;
    logic        ex_pred_taken, br_less, br_equal;
    logic        br_unsigned, br_taken, mispredict;
    logic [31:0] redirect_pc, br_count, miss_count;

    int n_cmp = 0;
    int n_err = 0;

    branch_predictor #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst), .pc_f_i(pc_f),
        .pred_taken_o(pred_taken), .pred_pc_o(pred_pc),
        .ex_valid_i(ex_valid), .ex_is_br_i(ex_is_br), .ex_pc_i(ex_pc),
        .ex_target_i(ex_target), .ex_funct3_i(ex_funct3),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_pc_i(ex_pred_pc),
        .br_less_i(br_less), .br_equal_i(br_equal),
        .br_unsigned_o(br_unsigned), .br_taken_o(br_taken),
        .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
        .br_count_o(br_count), .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid [NENT];
    int          m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    logic [31:0] m_br, m_miss;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) % NENT);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> (INDEX_W + 2)) % (1 << TAG_W));
    endfunction

    // Architectural branch semantics: bit2 picks less/equal, bit0 inverts
    function automatic void model_resolve(output bit res, output bit tk, output bit mp);
        bit legal, base;
        legal = !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        base  = ex_funct3[2] ? br_less : br_equal;
        res   = ex_valid && ex_is_br && legal;
        tk    = res && (base ^ ex_funct3[0]);
        mp    = res && ((tk != ex_pred_taken) || (tk && ex_pred_pc != ex_target));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NENT; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
            end
            m_br = 32'd0; m_miss = 32'd0;
        end else begin
            bit res, tk, mp;
            int ix;
            model_resolve(res, tk, mp);
            ix = idx_of(ex_pc);
            if (res) begin
                m_br = m_br + 32'd1;
                if (m_valid[ix] && m_tag[ix] == tag_of(ex_pc)) begin
                    if (tk) begin
                        m_ctr[ix] = (m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3;
                        m_tgt[ix] = ex_target;
                    end else begin
                        m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
                    end
                end else if (tk) begin
                    m_valid[ix] = 1; m_tag[ix] = tag_of(ex_pc);
                    m_tgt[ix] = ex_target; m_ctr[ix] = 2;
                end
            end
            if (mp) m_miss = m_miss + 32'd1;
        end
    end

    // Per-cycle compare against the model, mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            bit res, tk, mp, hit, pt;
            int fi;
            model_resolve(res, tk, mp);
            fi  = idx_of(pc_f);
            hit = m_valid[fi] && m_tag[fi] == tag_of(pc_f);
            pt  = hit && m_ctr[fi] >= 2;
            chk("pred_taken", 32'(pred_taken), 32'(pt));
            chk("pred_pc", pred_pc, pt ? m_tgt[fi] : pc_f + 32'd4);
            chk("br_unsigned", 32'(br_unsigned), 32'(ex_funct3[1]));
            chk("br_taken", 32'(br_taken), 32'(tk));
            chk("mispredict", 32'(mispredict), 32'(mp));
            chk("redirect_pc", redirect_pc, tk ? ex_target : ex_pc + 32'd4);
            chk("br_count", br_count, m_br);
            chk("miss_count", miss_count, m_miss);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        pc_f = fpc; ex_valid = 1'b0; ex_is_br = 1'b0;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] tgt,
                      input logic eq, input logic lt, input logic ptk, input logic [31:0] ppc);
        ex_valid = 1'b1; ex_is_br = 1'b1; ex_pc = pc; ex_funct3 = f3; ex_target = tgt;
        br_equal = eq; br_less = lt; ex_pred_taken = ptk; ex_pred_pc = ppc;
    endtask

    initial begin
        rst = 1'b1; pc_f = 32'h100; ex_valid = 1'b0; ex_is_br = 1'b0;
        ex_pc = 32'd0; ex_target = 32'd0; ex_funct3 = 3'd0; ex_pred_taken = 1'b0;
        ex_pred_pc = 32'd0; br_less = 1'b0; br_equal = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mid();
        chk("rst pred_taken", 32'(pred_taken), 32'd0);
        chk("rst pred_pc", pred_pc, 32'h104);
        chk("rst br_count", br_count, 32'd0);
        chk("rst miss_count", miss_count, 32'd0);

        // First BEQ taken, predicted not-taken
        step(); br(32'h100, 3'b000, 32'h80, 1'b1, 1'b0, 1'b0, 32'h104);
        mid();
        chk("beq br_taken", 32'(br_taken), 32'd1);
        chk("beq mispredict", 32'(mispredict), 32'd1);
        chk("beq redirect", redirect_pc, 32'h80);
        chk("beq no bypass", 32'(pred_taken), 32'd0);
        step(); idle(32'h100);
        mid();
        chk("alloc pred_taken", 32'(pred_taken), 32'd1);
        chk("alloc pred_pc", pred_pc, 32'h80);
        chk("alloc br_count", br_count, 32'd1);
        chk("alloc miss_count", miss_count, 32'd1);

        for (int i = 0; i < 3; i++) begin
            step(); br(32'h100, 3'b000, 32'h80, 1'b1, 1'b0, 1'b1, 32'h80);
        end
        step(); br(32'h100, 3'b000, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
        step(); idle(32'h100);
        mid();
        chk("sat then dec pred", 32'(pred_taken), 32'd1);
        step(); br(32'h100, 3'b000, 32'h80, 1'b0, 1'b0, 1'b1, 32'h80);
        step(); idle(32'h100);
        mid();
        chk("ctr01 pred_taken", 32'(pred_taken), 32'd0);
        chk("ctr01 pred_pc", pred_pc, 32'h104);
        chk("ctr01 br_count", br_count, 32'd6);
        chk("ctr01 miss_count", miss_count, 32'd3);

        // funct3 decode sweep
        step(); br(32'h40, 3'b110, 32'h20, 1'b0, 1'b1, 1'b0, 32'h44);
        mid();
        chk("bltu unsigned", 32'(br_unsigned), 32'd1);
        chk("bltu taken", 32'(br_taken), 32'd1);
        step(); br(32'h44, 3'b111, 32'h20, 1'b0, 1'b1, 1'b0, 32'h48);
        mid();
        chk("bgeu taken", 32'(br_taken), 32'd0);
        chk("bgeu redirect", redirect_pc, 32'h48);
        step(); br(32'h48, 3'b011, 32'h20, 1'b1, 1'b1, 1'b1, 32'h20);
        mid();
        chk("f3 011 taken", 32'(br_taken), 32'd0);
        chk("f3 011 mispredict", 32'(mispredict), 32'd0);
        step(); br(32'h50, 3'b100, 32'h20, 1'b0, 1'b0, 1'b0, 32'h54);
        step(); br(32'h54, 3'b101, 32'h24, 1'b0, 1'b0, 1'b0, 32'h58);
        mid();
        chk("bge signed", 32'(br_unsigned), 32'd0);
        chk("bge taken", 32'(br_taken), 32'd1);
        step(); br(32'h58, 3'b010, 32'h20, 1'b1, 1'b1, 1'b0, 32'h5c);
        step(); idle(32'h40);
        mid();
        chk("sweep br_count", br_count, 32'd10);
        chk("sweep miss_count", miss_count, 32'd5);

        // Alias into index 0 with a different tag
        step(); br(32'h200, 3'b000, 32'h300, 1'b1, 1'b0, 1'b0, 32'h204);
        step(); idle(32'h100);
        mid();
        chk("alias old tag", 32'(pred_taken), 32'd0);
        step(); idle(32'h200);
        mid();
        chk("alias new pred", 32'(pred_taken), 32'd1);
        chk("alias new pc", pred_pc, 32'h300);
        step(); br(32'h200, 3'b000, 32'h300, 1'b1, 1'b0, 1'b1, 32'h280);
        mid();
        chk("wrong target mp", 32'(mispredict), 32'd1);
        step(); idle(32'h200);
        mid();
        chk("alias br_count", br_count, 32'd12);
        chk("alias miss_count", miss_count, 32'd7);

        // Counter wrap
        step();
        force dut.br_count_q = 32'hFFFF_FFFF;
        #1 release dut.br_count_q;
        m_br = 32'hFFFF_FFFF;
        step(); br(32'h200, 3'b001, 32'h300, 1'b0, 1'b0, 1'b1, 32'h300);
        step(); idle(32'h200);
        mid();
        chk("wrap br_count", br_count, 32'd0);
        chk("wrap miss_count", miss_count, 32'd7);

        // Reset in the middle of a resolving cycle
        step(); br(32'h200, 3'b000, 32'h300, 1'b1, 1'b0, 1'b1, 32'h300);
        #1 rst = 1'b1;
        #1;
        chk("midrst br_count", br_count, 32'd0);
        chk("midrst miss_count", miss_count, 32'd0);
        chk("midrst pred_taken", 32'(pred_taken), 32'd0);
        chk("midrst pred_pc", pred_pc, 32'h204);
        step(); rst = 1'b0; idle(32'h200);
        mid();
        chk("postrst pred_taken", 32'(pred_taken), 32'd0);
        chk("postrst br_count", br_count, 32'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
